// File: rtl/flash_write_frame_loader_pkg.sv
// Shared constants and FSM state type for the flash write frame loader.
// Frame layout: SYNC, addr[31:0] MSB first, len[15:0] MSB first, len payload bytes.
package flash_write_frame_loader_pkg;

  localparam logic [7:0]  FRAME_SYNC = 8'hA5;
  localparam int unsigned PAGE_BYTES = 256;

  typedef enum logic [2:0] {
    HUNT      = 3'd0,
    ADDR      = 3'd1,
    LEN       = 3'd2,
    PREFILL   = 3'd3,
    LAUNCH    = 3'd4,
    STREAM    = 3'd5,
    WAIT_DONE = 3'd6
  } state_t;

  // Bytes that must be buffered before the write controller is started.
  function automatic logic [15:0] prefill_target(input logic [15:0] len, input int unsigned page);
    return (32'(len) < page) ? len : page[15:0];
  endfunction

endpackage

// File: rtl/flash_write_frame_loader_if.sv
// Receive-stream and write-controller signals of the frame loader.
// slave: the loader itself; master: host/UART side plus write controller.
interface flash_write_frame_loader_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        data_req;
  logic        write_finish;
  logic        pi_flag;
  logic [31:0] write_start_addr;
  logic [15:0] write_num;
  logic [7:0]  write_data;
  logic        busy;
  logic        frame_err;
  logic        underflow;

  modport slave (
    input  rx_data, rx_valid, data_req, write_finish,
    output rx_ready, pi_flag, write_start_addr, write_num, write_data,
           busy, frame_err, underflow
  );

  modport master (
    output rx_data, rx_valid, data_req, write_finish,
    input  rx_ready, pi_flag, write_start_addr, write_num, write_data,
           busy, frame_err, underflow
  );

endinterface

// File: rtl/flash_write_frame_loader_byte_fifo.sv
// Synchronous byte FIFO, depth 2**AW, with a registered show-ahead head (dout).
// flush has priority over push/pop; dout holds across flush and when emptied.
module flash_byte_fifo #(
  parameter int unsigned AW = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  output logic [7:0]  dout,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty,
  input  logic        flush
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count_q;
  logic [7:0]    dout_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = count_q[AW];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rd_next = rd_ptr_q + 1'b1;
  assign count   = count_q;
  assign dout    = dout_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_next;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Head follows the next stored byte, or the incoming byte when it becomes the head.
      if (do_pop) begin
        if (count_q != (AW+1)'(1)) dout_q <= mem_q[rd_next];
        else if (do_push)          dout_q <= din;
      end else if (do_push && empty) begin
        dout_q <= din;
      end
    end
  end

endmodule

// File: rtl/flash_write_frame_loader.sv
// Frame parser feeding the SPI flash write controller: buffers payload, launches with pi_flag.
// Optional inter-byte timeout enabled by defining TIMEOUT_EN.
module flash_write_frame_loader
  import flash_write_frame_loader_pkg::*;
#(
  parameter int unsigned FIFO_AW     = 9,
  parameter int unsigned PAGE_BYTES  = flash_write_frame_loader_pkg::PAGE_BYTES,
  parameter logic [31:0] TIMEOUT_CYC = 32'd5_000_000
) (
  input  logic                        system_clk,
  input  logic                        system_reset_n,
  flash_write_frame_loader_if.slave   bus
);

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   rcvd_q, rcvd_d;
  logic [1:0]    idx_q, idx_d;
  logic          frame_err_q, frame_err_d;
  logic          underflow_q, underflow_d;

  logic          fifo_push, fifo_pop, fifo_flush;
  logic          fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  logic [7:0]    fifo_dout;

  logic          rx_ready;
  logic          accept;
  logic          stream_phase;
  logic          timeout;
  logic [16:0]   post_count;

  flash_byte_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (system_clk),
    .rst_n (system_reset_n),
    .push  (fifo_push),
    .din   (bus.rx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty),
    .flush (fifo_flush)
  );

  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      HUNT, ADDR, LEN: rx_ready = 1'b1;
      PREFILL, STREAM: rx_ready = ~fifo_full & (rcvd_q < len_q);
      default:         rx_ready = 1'b0;
    endcase
  end

  assign accept       = bus.rx_valid & rx_ready;
  assign stream_phase = (state_q == STREAM) || (state_q == WAIT_DONE);

`ifdef TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        tmo_run;

  assign tmo_run = (state_q == ADDR) || (state_q == LEN) || (state_q == PREFILL);
  assign timeout = tmo_run & ~accept & (tmo_q == TIMEOUT_CYC - 32'd1);

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n)          tmo_q <= '0;
    else if (!tmo_run || accept)  tmo_q <= '0;
    else                          tmo_q <= tmo_q + 32'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    rcvd_d      = rcvd_q;
    idx_d       = idx_q;
    frame_err_d = 1'b0;
    underflow_d = underflow_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    post_count  = '0;

    if (stream_phase && bus.data_req) begin
      fifo_pop = 1'b1;
      if (fifo_empty) underflow_d = 1'b1;
    end

    case (state_q)
      HUNT: begin
        if (accept && bus.rx_data == FRAME_SYNC) begin
          state_d = ADDR;
          idx_d   = '0;
        end
      end
      ADDR: begin
        if (accept) begin
          addr_d = {addr_q[23:0], bus.rx_data};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = LEN;
        end
      end
      LEN: begin
        if (accept) begin
          len_d = {len_q[7:0], bus.rx_data};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd1) begin
            idx_d = '0;
            if ({len_q[7:0], bus.rx_data} == 16'd0) begin
              frame_err_d = 1'b1;
              state_d     = HUNT;
            end else begin
              rcvd_d  = '0;
              state_d = PREFILL;
            end
          end
        end
      end
      PREFILL: begin
        if (accept) begin
          fifo_push = 1'b1;
          rcvd_d    = rcvd_q + 16'd1;
        end
        post_count = 17'(fifo_count) + 17'(fifo_push);
        if (post_count >= {1'b0, prefill_target(len_q, PAGE_BYTES)}) state_d = LAUNCH;
      end
      LAUNCH: begin
        underflow_d = 1'b0;
        state_d     = STREAM;
      end
      STREAM: begin
        if (accept) begin
          fifo_push = 1'b1;
          rcvd_d    = rcvd_q + 16'd1;
        end
        // An early finish abandons the rest of the frame, so drop whatever is buffered.
        if (bus.write_finish) begin
          fifo_flush = 1'b1;
          state_d    = HUNT;
        end else if (rcvd_d == len_q) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.write_finish) begin
          fifo_flush = 1'b1;
          state_d    = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase

    if (timeout) begin
      frame_err_d = 1'b1;
      fifo_flush  = 1'b1;
      fifo_push   = 1'b0;
      state_d     = HUNT;
    end
  end

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q     <= HUNT;
      addr_q      <= '0;
      len_q       <= '0;
      rcvd_q      <= '0;
      idx_q       <= '0;
      frame_err_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      rcvd_q      <= rcvd_d;
      idx_q       <= idx_d;
      frame_err_q <= frame_err_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.rx_ready         = rx_ready;
  assign bus.pi_flag          = (state_q == LAUNCH);
  assign bus.write_start_addr = addr_q;
  assign bus.write_num        = len_q;
  assign bus.write_data       = fifo_dout;
  assign bus.busy             = (state_q != HUNT);
  assign bus.frame_err        = frame_err_q;
  assign bus.underflow        = underflow_q;

endmodule
